// File: rtl/adder_slice_sequencer.sv
// Two-requester WIDTH-bit add/subtract unit that reuses one 8-bit carry-lookahead
// slice over NSLICE byte passes, carrying between passes through a register.
module adder_slice_sequencer #(
    parameter  int NSLICE = 4,
    localparam int WIDTH  = 8 * NSLICE
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             sub0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             sub1,
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    // Handshake: a request is accepted when the unit is IDLE at a rising edge;
    // ack<g> pulses for the following cycle, after which req may drop and the
    // operands may change. done pulses once with result/cout/ovf/done_id valid.
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_grant;
    logic             w_gnt_id;
    logic             w_last;
    logic [WIDTH-1:0] w_a_sel;
    logic [WIDTH-1:0] w_b_sel;
    logic             w_sub_sel;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic             r_sa;
    logic             r_sb;
    logic             r_owner;
    logic             r_last_grant;
    logic [KW-1:0]    r_k;

    logic [7:0]       w_sum;
    logic             w_gg;
    logic             w_pp;
    logic             w_cout;

    // 8-bit lookahead slice: returns {group generate, group propagate, sum}.
    function automatic logic [9:0] cla8(input logic [7:0] a, input logic [7:0] b,
                                        input logic cin);
        logic [7:0] g;
        logic [7:0] p;
        logic [7:0] c;
        logic       ci;
        logic       pr;
        logic       gg;
        logic       pp;
        g = a & b;
        p = a ^ b;
        for (int i = 0; i < 8; i++) begin
            ci = 1'b0;
            pr = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                ci = ci | (pr & g[j]);
                pr = pr & p[j];
            end
            c[i] = ci | (pr & cin);
        end
        gg = 1'b0;
        pp = 1'b1;
        for (int j = 7; j >= 0; j--) begin
            gg = gg | (pp & g[j]);
            pp = pp & p[j];
        end
        return {gg, pp, p ^ c};
    endfunction

    always_comb begin
        {w_gg, w_pp, w_sum} = cla8(r_a[7:0], r_b[7:0], r_carry);
        w_cout = w_gg | (w_pp & r_carry);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
        w_gnt_id  = 1'b0;
        w_last    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_grant  = 1'b1;
                    w_gnt_id = (req0 && req1) ? ~r_last_grant : req1;
                    w_next   = RUN;
                end
            end
            RUN: begin
                w_last = (r_k == KW'(NSLICE - 1));
                if (w_last) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        w_a_sel   = w_gnt_id ? a1 : a0;
        w_sub_sel = w_gnt_id ? sub1 : sub0;
        w_b_sel   = (w_gnt_id ? b1 : b0) ^ {WIDTH{w_sub_sel}};
    end

    // Operands shift down one byte per pass; finished bytes shift in at the top
    // of r_acc so the full sum is aligned after the last pass.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_carry      <= 1'b0;
            r_sa         <= 1'b0;
            r_sb         <= 1'b0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_k          <= '0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            done_id      <= 1'b0;
            result       <= '0;
            cout         <= 1'b0;
            ovf          <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            done <= 1'b0;
            if (w_grant) begin
                r_a          <= w_a_sel;
                r_b          <= w_b_sel;
                r_carry      <= w_sub_sel;
                r_sa         <= w_a_sel[WIDTH-1];
                r_sb         <= w_b_sel[WIDTH-1];
                r_owner      <= w_gnt_id;
                r_last_grant <= w_gnt_id;
                r_k          <= '0;
                ack0         <= ~w_gnt_id;
                ack1         <= w_gnt_id;
                busy         <= 1'b1;
            end else if (r_state == RUN) begin
                r_a     <= r_a >> 8;
                r_b     <= r_b >> 8;
                r_acc   <= {w_sum, r_acc[WIDTH-1:8]};
                r_carry <= w_cout;
                r_k     <= r_k + 1'b1;
                if (w_last) begin
                    result  <= {w_sum, r_acc[WIDTH-1:8]};
                    cout    <= w_cout;
                    ovf     <= (r_sa == r_sb) && (w_sum[7] != r_sa);
                    done    <= 1'b1;
                    done_id <= r_owner;
                    busy    <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_adder_slice_sequencer.sv
// Directed bench for adder_slice_sequencer (NSLICE=4, WIDTH=32).
module tb_adder_slice_sequencer;
    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         req0, sub0, req1, sub1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         ack0, ack1, busy, done, done_id, cout, ovf;
    logic [W-1:0] result;

    int errors = 0;
    int checks = 0;

    adder_slice_sequencer #(.NSLICE(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0(req0), .a0(a0), .b0(b0), .sub0(sub0),
        .req1(req1), .a1(a1), .b1(b1), .sub1(sub1),
        .ack0(ack0), .ack1(ack1), .busy(busy), .done(done), .done_id(done_id),
        .result(result), .cout(cout), .ovf(ovf)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        a0 = 32'h1234_5678; b0 = 32'h1111_1111; sub0 = 1'b0;
        a1 = 32'hDEAD_BEEF; b1 = 32'h0000_0001; sub1 = 1'b1;
        repeat (3) begin
            @(negedge clock);
            checks++;
            if ({ack0, ack1, busy, done, done_id, cout, ovf, result} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got %h expected 0",
                         {ack0, ack1, busy, done, done_id, cout, ovf, result});
            end
        end
        reset_n = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) begin
            @(negedge clock);
            checks++;
            if ({ack0, ack1, busy, done} !== 4'b0) begin
                errors++;
                $display("FAIL idle_after_reset: ack0/ack1/busy/done=%b expected 0000",
                         {ack0, ack1, busy, done});
            end
        end
    endtask

    task automatic do_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit sub, input logic [W-1:0] exp_res, input bit exp_cout,
                         input bit exp_ovf, input string name);
        bit got;
        bit ack_bad;
        int lat;
        int busy_cnt;
        @(negedge clock);
        if (id) begin req1 = 1'b1; a1 = a; b1 = b; sub1 = sub; end
        else    begin req0 = 1'b1; a0 = a; b0 = b; sub0 = sub; end
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (id ? ack1 : ack0) begin got = 1'b1; break; end
        end
        req0 = 1'b0; req1 = 1'b0;
        a0 = '1; b0 = '1; a1 = '1; b1 = '1;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s ack_timeout: no ack%0d within 10 cycles", name, id);
            return;
        end
        checks++;
        if ((id ? ack0 : ack1) !== 1'b0) begin
            errors++;
            $display("FAIL %s wrong_ack: other ack=%b expected 0", name, id ? ack0 : ack1);
        end
        busy_cnt = busy ? 1 : 0;
        got = 1'b0; lat = 0; ack_bad = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (ack0 || ack1) ack_bad = 1'b1;
            if (done) begin got = 1'b1; lat = i; break; end
            if (busy) busy_cnt++;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s done_timeout: no done within 10 cycles of ack", name);
            return;
        end
        checks++;
        if (ack_bad) begin
            errors++;
            $display("FAIL %s ack_pulse: ack longer than one cycle, expected single pulse", name);
        end
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL %s done_latency: got %0d expected 4", name, lat);
        end
        checks++;
        if (busy_cnt !== 4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: cycles=%0d busy_at_done=%b expected 4/0", name, busy_cnt, busy);
        end
        checks++;
        if (done_id !== id) begin
            errors++;
            $display("FAIL %s done_id: got %b expected %b", name, done_id, id);
        end
        checks++;
        if (result !== exp_res) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", name, result, exp_res);
        end
        checks++;
        if ({cout, ovf} !== {exp_cout, exp_ovf}) begin
            errors++;
            $display("FAIL %s cout_ovf: got %b%b expected %b%b", name, cout, ovf, exp_cout, exp_ovf);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || result !== exp_res || done_id !== id) begin
            errors++;
            $display("FAIL %s hold: done=%b result=%h id=%b expected 0/%h/%b",
                     name, done, result, done_id, exp_res, id);
        end
    endtask

    task automatic test_carry_chain();
        do_op(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, "carry_chain");
        do_op(1'b0, 32'h1234_5678, 32'h0EDC_BA98, 1'b0, 32'h2111_1110, 1'b0, 1'b0, "multi_carry");
    endtask

    task automatic test_subtract();
        do_op(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_borrow");
        do_op(1'b1, 32'h0000_0100, 32'h0000_0001, 1'b1, 32'h0000_00FF, 1'b1, 1'b0, "sub_no_borrow");
    endtask

    task automatic test_overflow();
        do_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "pos_ovf");
        do_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "wrap_cout");
        do_op(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "neg_ovf_sub");
    endtask

    task automatic test_arbitration();
        int ack_id[4];
        int ack_cyc[4];
        int dn_id[4];
        logic [W-1:0] dn_res[4];
        int n_ack, n_done;
        bit both;
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        req0 = 1'b1; a0 = 32'h0000_0010; b0 = 32'h0000_0020; sub0 = 1'b0;
        req1 = 1'b1; a1 = 32'h0000_0100; b1 = 32'h0000_0001; sub1 = 1'b1;
        n_ack = 0; n_done = 0; both = 1'b0;
        for (int c = 0; c < 40 && n_done < 4; c++) begin
            @(negedge clock);
            if (ack0 && ack1) both = 1'b1;
            if ((ack0 || ack1) && n_ack < 4) begin
                ack_id[n_ack] = ack0 ? 0 : 1;
                ack_cyc[n_ack] = c;
                n_ack++;
            end
            if (done) begin
                dn_id[n_done] = int'(done_id);
                dn_res[n_done] = result;
                n_done++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (n_ack !== 4 || n_done !== 4 || both) begin
            errors++;
            $display("FAIL arb_counts: acks=%0d dones=%0d simultaneous=%b expected 4/4/0",
                     n_ack, n_done, both);
            return;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ack_id[i] !== (i % 2)) begin
                errors++;
                $display("FAIL arb_order[%0d]: got ack%0d expected ack%0d", i, ack_id[i], i % 2);
            end
            checks++;
            if (dn_id[i] !== ack_id[i]) begin
                errors++;
                $display("FAIL arb_done_id[%0d]: got %0d expected %0d", i, dn_id[i], ack_id[i]);
            end
            checks++;
            if (dn_res[i] !== ((i % 2) ? 32'h0000_00FF : 32'h0000_0030)) begin
                errors++;
                $display("FAIL arb_result[%0d]: got %h expected %h", i, dn_res[i],
                         (i % 2) ? 32'h0000_00FF : 32'h0000_0030);
            end
            if (i > 0) begin
                checks++;
                if (ack_cyc[i] - ack_cyc[i-1] !== 5) begin
                    errors++;
                    $display("FAIL arb_spacing[%0d]: got %0d cycles expected 5", i,
                             ack_cyc[i] - ack_cyc[i-1]);
                end
            end
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_abort();
        bit got;
        bit saw_done;
        @(negedge clock);
        req0 = 1'b1; a0 = 32'h0000_00FF; b0 = 32'h0000_0001; sub0 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (ack0) begin got = 1'b1; break; end
        end
        req0 = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL abort_ack_timeout: no ack0 within 10 cycles");
            return;
        end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ack0, ack1, busy, done, done_id, cout, ovf, result} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got %h expected 0",
                     {ack0, ack1, busy, done, done_id, cout, ovf, result});
        end
        saw_done = 1'b0;
        @(negedge clock);
        if (done) saw_done = 1'b1;
        reset_n = 1'b1;
        repeat (6) begin
            @(negedge clock);
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort_no_done: done/busy seen after abort, expected none");
        end
        do_op(1'b0, 32'h1234_5678, 32'h0EDC_BA98, 1'b0, 32'h2111_1110, 1'b0, 1'b0, "after_abort");
    endtask

    initial begin
        test_reset();
        test_carry_chain();
        test_subtract();
        test_overflow();
        test_arbitration();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
